// File: rtl/axi4_burst_ram.sv
// AXI4 slave memory model: FIXED/INCR/WRAP bursts, narrow writes, DECERR/SLVERR responses.
// Latency: first R beat RD_LATENCY cycles after AR accept; B the cycle after the burst's final W beat.
// Backpressure: one outstanding write and one outstanding read; R/B held stable until r_ready/b_ready.
module axi4_burst_ram #(
    parameter int                DATA_W     = 64,
    parameter int                ADDR_W     = 32,
    parameter int                ID_W       = 4,
    parameter int                MEM_BYTES  = 131072,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
    parameter int                RD_LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                aw_valid,
    output logic                aw_ready,
    input  logic [ID_W-1:0]     aw_id,
    input  logic [ADDR_W-1:0]   aw_addr,
    input  logic [7:0]          aw_len,
    input  logic [2:0]          aw_size,
    input  logic [1:0]          aw_burst,
    input  logic                w_valid,
    output logic                w_ready,
    input  logic [DATA_W-1:0]   w_data,
    input  logic [DATA_W/8-1:0] w_strb,
    input  logic                w_last,
    output logic                b_valid,
    input  logic                b_ready,
    output logic [ID_W-1:0]     b_id,
    output logic [1:0]          b_resp,
    input  logic                ar_valid,
    output logic                ar_ready,
    input  logic [ID_W-1:0]     ar_id,
    input  logic [ADDR_W-1:0]   ar_addr,
    input  logic [7:0]          ar_len,
    input  logic [2:0]          ar_size,
    input  logic [1:0]          ar_burst,
    output logic                r_valid,
    input  logic                r_ready,
    output logic [ID_W-1:0]     r_id,
    output logic [DATA_W-1:0]   r_data,
    output logic [1:0]          r_resp,
    output logic                r_last
);

    localparam int STRB_W    = DATA_W / 8;
    localparam int LANE_BITS = $clog2(STRB_W);
    localparam int WORDS     = MEM_BYTES / STRB_W;
    localparam int WIDX_W    = $clog2(WORDS);
    // Wide enough that burst end addresses never overflow during range checks.
    localparam int XW        = ADDR_W + 17;
    localparam int LAT_W     = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    typedef enum logic [1:0] {WA_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic [1:0] {RA_IDLE, R_WAIT, R_DATA} rd_state_t;

    // Backing store; never reset so a preload survives reset.
    logic [DATA_W-1:0] mem [WORDS];

    // Whole-burst response decided once at address accept.
    function automatic logic [1:0] calc_resp(input logic [ADDR_W-1:0] a, input logic [7:0] len,
                                             input logic [2:0] size, input logic [1:0] burst);
        logic [XW-1:0] sz, tot, aa, alo, ahi;
        sz  = XW'(1) << size;
        tot = (XW'(len) + XW'(1)) << size;
        aa  = XW'(a);
        case (burst)
            BURST_FIXED: begin alo = aa; ahi = (aa & ~(sz - XW'(1))) + sz - XW'(1); end
            BURST_WRAP:  begin alo = aa & ~(tot - XW'(1)); ahi = alo + tot - XW'(1); end
            default:     begin alo = aa; ahi = (aa & ~(sz - XW'(1))) + tot - XW'(1); end
        endcase
        if (alo < XW'(BASE_ADDR) || ahi >= XW'(BASE_ADDR) + XW'(MEM_BYTES))
            return RESP_DECERR;
        if (sz > XW'(STRB_W) || burst == 2'd3)
            return RESP_SLVERR;
        if (burst == BURST_WRAP &&
            (!(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15) || (aa & (sz - XW'(1))) != '0))
            return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    // Address of the following beat; INCR re-aligns after an unaligned first beat.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a, input logic [7:0] len,
                                                    input logic [2:0] size, input logic [1:0] burst);
        logic [ADDR_W-1:0] sz, tot, lower, inc;
        sz    = ADDR_W'(1) << size;
        tot   = (ADDR_W'(len) + ADDR_W'(1)) << size;
        lower = a & ~(tot - ADDR_W'(1));
        inc   = (a & ~(sz - ADDR_W'(1))) + sz;
        case (burst)
            BURST_FIXED: return a;
            BURST_WRAP:  return (inc == lower + tot) ? lower : inc;
            default:     return inc;
        endcase
    endfunction

    function automatic logic [WIDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        return WIDX_W'(off >> LANE_BITS);
    endfunction

    // ---------------- write path ----------------
    wr_state_t         wst_q, wst_d;
    logic              aw_ready_q, aw_ready_d, w_ready_q, w_ready_d, b_valid_q, b_valid_d;
    logic [1:0]        b_resp_q, b_resp_d, wresp_q, wresp_d, wburst_q, wburst_d;
    logic [ID_W-1:0]   wid_q, wid_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wlen_q, wlen_d, wcnt_q, wcnt_d;
    logic [2:0]        wsize_q, wsize_d;
    logic              w_hs, w_end, mem_we;

    assign w_hs   = w_valid & w_ready_q;
    assign w_end  = w_last | (wcnt_q == wlen_q);
    assign mem_we = w_hs & (wst_q == W_DATA) & (wresp_q == RESP_OKAY);

    // Write FSM next state: accept AW, stream W beats, hold B until taken.
    always_comb begin
        wst_d = wst_q; aw_ready_d = aw_ready_q; w_ready_d = w_ready_q; b_valid_d = b_valid_q;
        b_resp_d = b_resp_q; wresp_d = wresp_q; wburst_d = wburst_q; wid_d = wid_q;
        waddr_d = waddr_q; wlen_d = wlen_q; wcnt_d = wcnt_q; wsize_d = wsize_q;
        case (wst_q)
            WA_IDLE: begin
                aw_ready_d = 1'b1;
                if (aw_valid && aw_ready_q) begin
                    wid_d      = aw_id;
                    waddr_d    = aw_addr;
                    wlen_d     = aw_len;
                    wsize_d    = aw_size;
                    wburst_d   = aw_burst;
                    wcnt_d     = 8'd0;
                    wresp_d    = calc_resp(aw_addr, aw_len, aw_size, aw_burst);
                    aw_ready_d = 1'b0;
                    w_ready_d  = 1'b1;
                    wst_d      = W_DATA;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    waddr_d = next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
                    wcnt_d  = wcnt_q + 8'd1;
                    if (w_end) begin
                        // A w_last that disagrees with the beat count is a length error.
                        b_resp_d  = (wresp_q == RESP_OKAY && (w_last != (wcnt_q == wlen_q)))
                                    ? RESP_SLVERR : wresp_q;
                        w_ready_d = 1'b0;
                        b_valid_d = 1'b1;
                        wst_d     = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (b_valid_q && b_ready) begin
                    b_valid_d  = 1'b0;
                    aw_ready_d = 1'b1;
                    wst_d      = WA_IDLE;
                end
            end
            default: wst_d = WA_IDLE;
        endcase
    end

    // Write FSM state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wst_q <= WA_IDLE; aw_ready_q <= 1'b0; w_ready_q <= 1'b0; b_valid_q <= 1'b0;
            b_resp_q <= '0; wresp_q <= '0; wburst_q <= '0; wid_q <= '0;
            waddr_q <= '0; wlen_q <= '0; wcnt_q <= '0; wsize_q <= '0;
        end else begin
            wst_q <= wst_d; aw_ready_q <= aw_ready_d; w_ready_q <= w_ready_d; b_valid_q <= b_valid_d;
            b_resp_q <= b_resp_d; wresp_q <= wresp_d; wburst_q <= wburst_d; wid_q <= wid_d;
            waddr_q <= waddr_d; wlen_q <= wlen_d; wcnt_q <= wcnt_d; wsize_q <= wsize_d;
        end
    end

    // Byte-enabled commit of each accepted W beat of an error-free burst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (w_strb[i]) mem[word_idx(waddr_q)][8*i +: 8] <= w_data[8*i +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    rd_state_t         rst_st_q, rst_st_d;
    logic              ar_ready_q, ar_ready_d, r_valid_q, r_valid_d, r_last_q, r_last_d;
    logic [DATA_W-1:0] r_data_q, r_data_d;
    logic [1:0]        r_resp_q, r_resp_d, rresp_q, rresp_d, rburst_q, rburst_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d, rnext, load_addr;
    logic [7:0]        rlen_q, rlen_d, rcnt_q, rcnt_d;
    logic [2:0]        rsize_q, rsize_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              load;

    // Read FSM next state: accept AR, wait out the latency, present beats until r_last is taken.
    always_comb begin
        rst_st_d = rst_st_q; ar_ready_d = ar_ready_q; r_valid_d = r_valid_q; r_last_d = r_last_q;
        r_data_d = r_data_q; r_resp_d = r_resp_q; rresp_d = rresp_q; rburst_d = rburst_q;
        rid_d = rid_q; raddr_d = raddr_q; rlen_d = rlen_q; rcnt_d = rcnt_q; rsize_d = rsize_q;
        lat_d = lat_q;
        load      = 1'b0;
        load_addr = raddr_q;
        rnext     = next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
        case (rst_st_q)
            RA_IDLE: begin
                ar_ready_d = 1'b1;
                if (ar_valid && ar_ready_q) begin
                    rid_d      = ar_id;
                    raddr_d    = ar_addr;
                    rlen_d     = ar_len;
                    rsize_d    = ar_size;
                    rburst_d   = ar_burst;
                    rcnt_d     = 8'd0;
                    rresp_d    = calc_resp(ar_addr, ar_len, ar_size, ar_burst);
                    lat_d      = LAT_W'(RD_LATENCY - 1);
                    ar_ready_d = 1'b0;
                    rst_st_d   = R_WAIT;
                end
            end
            R_WAIT: begin
                if (lat_q == '0) begin
                    load      = 1'b1;
                    r_valid_d = 1'b1;
                    r_resp_d  = rresp_q;
                    r_last_d  = (rlen_q == 8'd0);
                    rst_st_d  = R_DATA;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            R_DATA: begin
                if (r_valid_q && r_ready) begin
                    if (r_last_q) begin
                        r_valid_d  = 1'b0;
                        r_last_d   = 1'b0;
                        ar_ready_d = 1'b1;
                        rst_st_d   = RA_IDLE;
                    end else begin
                        load      = 1'b1;
                        load_addr = rnext;
                        raddr_d   = rnext;
                        rcnt_d    = rcnt_q + 8'd1;
                        r_last_d  = ((rcnt_q + 8'd1) == rlen_q);
                    end
                end
            end
            default: rst_st_d = RA_IDLE;
        endcase
        // mem is sampled before this edge's write lands, so a same-edge write is not seen.
        if (load) r_data_d = (rresp_q == RESP_OKAY) ? mem[word_idx(load_addr)] : '0;
    end

    // Read FSM state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_st_q <= RA_IDLE; ar_ready_q <= 1'b0; r_valid_q <= 1'b0; r_last_q <= 1'b0;
            r_data_q <= '0; r_resp_q <= '0; rresp_q <= '0; rburst_q <= '0;
            rid_q <= '0; raddr_q <= '0; rlen_q <= '0; rcnt_q <= '0; rsize_q <= '0; lat_q <= '0;
        end else begin
            rst_st_q <= rst_st_d; ar_ready_q <= ar_ready_d; r_valid_q <= r_valid_d; r_last_q <= r_last_d;
            r_data_q <= r_data_d; r_resp_q <= r_resp_d; rresp_q <= rresp_d; rburst_q <= rburst_d;
            rid_q <= rid_d; raddr_q <= raddr_d; rlen_q <= rlen_d; rcnt_q <= rcnt_d; rsize_q <= rsize_d;
            lat_q <= lat_d;
        end
    end

    assign aw_ready = aw_ready_q;
    assign w_ready  = w_ready_q;
    assign b_valid  = b_valid_q;
    assign b_id     = wid_q;
    assign b_resp   = b_resp_q;
    assign ar_ready = ar_ready_q;
    assign r_valid  = r_valid_q;
    assign r_id     = rid_q;
    assign r_data   = r_data_q;
    assign r_resp   = r_resp_q;
    assign r_last   = r_last_q;

endmodule

// File: tb/tb_axi4_burst_ram.sv
// Bench for axi4_burst_ram: read vector table plus hand sequences for writes, errors and reset.
// Latency: first R beat expected RD_LATENCY cycles after AR accept.
// Backpressure: r_ready randomly dropped on some reads, b_ready held low on one write.
module tb_axi4_burst_ram;

    localparam logic [31:0] BASE = 32'h8000_0000;
    localparam int          RDL  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        aw_valid = 0, aw_ready, w_valid = 0, w_ready, w_last = 0, b_valid, b_ready = 0;
    logic        ar_valid = 0, ar_ready, r_valid, r_ready = 0, r_last;
    logic [3:0]  aw_id = 0, ar_id = 0, b_id, r_id;
    logic [31:0] aw_addr = 0, ar_addr = 0;
    logic [7:0]  aw_len = 0, ar_len = 0, w_strb = 0;
    logic [2:0]  aw_size = 0, ar_size = 0;
    logic [1:0]  aw_burst = 0, ar_burst = 0, b_resp, r_resp;
    logic [63:0] w_data = 0, r_data;

    always #5 clk = ~clk;

    axi4_burst_ram #(.DATA_W(64), .ADDR_W(32), .ID_W(4), .MEM_BYTES(131072),
                     .BASE_ADDR(32'h8000_0000), .RD_LATENCY(RDL)) dut (
        .clk(clk), .rst(rst),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
        .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
        .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
        .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data),
        .r_resp(r_resp), .r_last(r_last)
    );

    typedef struct { logic [63:0] data; logic [1:0] resp; logic last; logic [3:0] id; } rbeat_t;
    typedef struct { logic [1:0] resp; logic [3:0] id; } bexp_t;
    typedef struct {
        logic [31:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst;
        logic [3:0] id; logic [1:0] resp; logic bp;
    } rvec_t;

    rbeat_t      rq[$];
    bexp_t       bq[$];
    rvec_t       rv[10];
    logic [63:0] mdl [0:63];
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name, input int n);
        checks++;
        errors++;
        $display("FAIL timeout_%s waited=%0d cycles", name, n);
    endtask

    // Beat address from first principles: wrap by modulo within the container.
    function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst, input int i);
        logic [31:0] sz, tot, lower;
        sz    = 32'd1 << size;
        tot   = (32'(len) + 32'd1) * sz;
        lower = (a / tot) * tot;
        case (burst)
            2'd0:    return a;
            2'd2:    return lower + ((a - lower + 32'(i) * sz) % tot);
            default: return (i == 0) ? a : (a / sz) * sz + 32'(i) * sz;
        endcase
    endfunction

    function automatic int midx(input logic [31:0] a);
        return int'(((a - BASE) >> 3) & 32'd63);
    endfunction

    task automatic send_ar(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] id);
        int n;
        @(negedge clk);
        ar_valid = 1; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst; ar_id = id;
        n = 0;
        while (!ar_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) timeout("ar_ready", n);
        @(negedge clk);
        ar_valid = 0;
    endtask

    task automatic do_read(input rvec_t v);
        rbeat_t      e;
        logic [31:0] ba;
        logic [67:0] prev;
        logic        stalled;
        int          n, lat;
        for (int i = 0; i <= int'(v.len); i++) begin
            ba = beat_addr(v.addr, v.len, v.size, v.burst, i);
            e.data = (v.resp == 2'd0) ? mdl[midx(ba)] : 64'd0;
            e.resp = v.resp;
            e.last = (i == int'(v.len));
            e.id   = v.id;
            rq.push_back(e);
        end
        send_ar(v.addr, v.len, v.size, v.burst, v.id);
        lat = 0;
        while (!r_valid && lat < 200) begin @(negedge clk); lat++; end
        chk("rd_latency", 128'(lat), 128'(RDL));
        n = 0; stalled = 0; prev = '0;
        while (rq.size() > 0 && n < 400) begin
            r_ready = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stalled) chk("r_stable", {r_data, r_resp, r_last, r_id[0]}, prev);
            if (r_valid && r_ready) begin
                e = rq.pop_front();
                chk("r_data", r_data, e.data);
                chk("r_resp", r_resp, e.resp);
                chk("r_last", r_last, e.last);
                chk("r_id",   r_id,   e.id);
                stalled = 0;
            end else if (r_valid) begin
                stalled = 1;
                prev = {r_data, r_resp, r_last, r_id[0]};
            end else begin
                stalled = 0;
            end
            @(negedge clk); n++;
        end
        r_ready = 0;
        if (n >= 400) begin timeout("r_beats", n); rq.delete(); end
        chk("r_done", r_valid, 1'b0);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [3:0] id, input int nbeats,
                            input int last_idx, input logic [63:0] dat, input logic [7:0] strb,
                            input logic commit, input logic [1:0] exp_b, input int hold);
        bexp_t       be;
        logic [31:0] ba;
        logic [63:0] d;
        int          n;
        be.resp = exp_b; be.id = id;
        bq.push_back(be);
        @(negedge clk);
        aw_valid = 1; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst; aw_id = id;
        n = 0;
        while (!aw_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) timeout("aw_ready", n);
        @(negedge clk);
        aw_valid = 0;
        for (int i = 0; i < nbeats; i++) begin
            d = dat * 64'(i + 1);
            w_valid = 1; w_data = d; w_strb = strb; w_last = (i == last_idx);
            n = 0;
            while (!w_ready && n < 200) begin @(negedge clk); n++; end
            if (n >= 200) timeout("w_ready", n);
            @(negedge clk);
            if (commit) begin
                ba = beat_addr(addr, len, size, burst, i);
                for (int b = 0; b < 8; b++) if (strb[b]) mdl[midx(ba)][8*b +: 8] = d[8*b +: 8];
            end
        end
        w_valid = 0; w_last = 0;
        n = 0;
        while (!b_valid && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) timeout("b_valid", n);
        for (int k = 0; k < hold; k++) begin
            b_ready = 0;
            chk("b_hold_valid", b_valid, 1'b1);
            chk("b_hold_id", b_id, id);
            @(negedge clk);
        end
        be = bq.pop_front();
        b_ready = 1;
        chk("b_resp", b_resp, be.resp);
        chk("b_id", b_id, be.id);
        @(negedge clk);
        b_ready = 0;
        repeat (3) begin chk("b_once", b_valid, 1'b0); @(negedge clk); end
    endtask

    initial begin
        logic [127:0] z;
        int           beats, n;
        z = '0;
        //        addr          len   size  burst id    resp  bp
        rv[0] = '{32'h8000_0000, 8'd3, 3'd3, 2'd1, 4'd5, 2'd0, 1'b0};
        rv[1] = '{32'h8000_0010, 8'd3, 3'd3, 2'd2, 4'd1, 2'd0, 1'b1};
        rv[2] = '{32'h8000_0008, 8'd2, 3'd3, 2'd0, 4'd2, 2'd0, 1'b1};
        rv[3] = '{32'h7FFF_FFF8, 8'd1, 3'd3, 2'd1, 4'd3, 2'd3, 1'b0};
        rv[4] = '{32'h8000_0000, 8'd1, 3'd4, 2'd1, 4'd4, 2'd2, 1'b0};
        rv[5] = '{32'h8000_0000, 8'd1, 3'd3, 2'd3, 4'd6, 2'd2, 1'b0};
        rv[6] = '{32'h8000_0000, 8'd2, 3'd3, 2'd2, 4'd7, 2'd2, 1'b0};
        rv[7] = '{32'h8000_0004, 8'd1, 3'd3, 2'd2, 4'd8, 2'd2, 1'b0};
        rv[8] = '{32'h8001_FFF8, 8'd1, 3'd3, 2'd1, 4'd9, 2'd3, 1'b0};
        rv[9] = '{32'h8000_0004, 8'd1, 3'd2, 2'd1, 4'd10, 2'd0, 1'b1};
        for (int i = 0; i < 64; i++) mdl[i] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_readies", {aw_ready, w_ready, ar_ready}, 3'b000);
        chk("rst_valids", {b_valid, r_valid, r_last}, 3'b000);
        chk("rst_r_data", r_data, z[63:0]);
        chk("rst_resp_id", {b_resp, r_resp, b_id, r_id}, 12'd0);
        rst = 0;
        repeat (2) @(negedge clk);

        // Preload 0x1111..0x4444 into the first 32 bytes
        do_write(32'h8000_0000, 8'd3, 3'd3, 2'd1, 4'd0, 4, 3, 64'h1111, 8'hFF, 1'b1, 2'd0, 0);

        for (int i = 0; i < 10; i++) do_read(rv[i]);

        // Narrow write into the upper half of word 0
        do_write(32'h8000_0004, 8'd0, 3'd2, 2'd1, 4'd2, 1, 0, 64'hAABBCCDD_00000000, 8'hF0, 1'b1, 2'd0, 0);
        chk("narrow_model", mdl[0], 64'hAABBCCDD_00001111);
        do_read('{32'h8000_0000, 8'd0, 3'd3, 2'd1, 4'd3, 2'd0, 1'b0});

        // Out-of-range write: both beats swallowed, nothing committed
        do_write(32'h8002_0000, 8'd1, 3'd3, 2'd1, 4'd4, 2, 1, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, 1'b0, 2'd3, 0);
        do_read('{32'h8000_0000, 8'd1, 3'd3, 2'd1, 4'd4, 2'd0, 1'b0});

        // Early w_last on beat 1 of a 4-beat write, B held off for 5 cycles
        do_write(32'h8000_0020, 8'd3, 3'd3, 2'd1, 4'd11, 2, 1, 64'h5555_0000_0000_0055, 8'hFF, 1'b1, 2'd2, 5);
        do_read('{32'h8000_0020, 8'd1, 3'd3, 2'd1, 4'd11, 2'd0, 1'b0});

        // Missing w_last on the final beat
        do_write(32'h8000_0040, 8'd1, 3'd3, 2'd1, 4'd12, 2, -1, 64'h0000_7777_0000_0007, 8'hFF, 1'b1, 2'd2, 0);

        // WRAP write starting mid-container, read back linearly
        do_write(32'h8000_0058, 8'd3, 3'd3, 2'd2, 4'd13, 4, 3, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1, 2'd0, 0);
        do_read('{32'h8000_0040, 8'd3, 3'd3, 2'd1, 4'd13, 2'd0, 1'b1});

        // Reset during beat 2 of an 8-beat read
        send_ar(32'h8000_0000, 8'd7, 3'd3, 2'd1, 4'd9);
        r_ready = 1; beats = 0; n = 0;
        while (beats < 2 && n < 200) begin
            if (r_valid) begin
                chk("rstrd_data", r_data, mdl[beats]);
                beats++;
            end
            @(negedge clk); n++;
        end
        if (n >= 200) timeout("rstrd_beats", n);
        chk("rstrd_pre_valid", r_valid, 1'b1);
        rst = 1;
        #1;
        chk("rstrd_r_valid", r_valid, 1'b0);
        chk("rstrd_outs", {r_last, ar_ready, aw_ready, r_id}, 7'd0);
        r_ready = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        do_read(rv[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always ends with its summary line.
    initial begin
        #500000;
        checks++;
        errors++;
        $display("FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
